// File: rtl/serial_add_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_add_ctrl : bit-serial add controller, one full-adder slice, LSB    |
// | first, valid/ready on both sides. Optional macro SERIAL_ADD_SUB_EN adds   |
// | a subtract mode (port sub).                                               |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_c_out;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_b_bit;
    logic             w_carry_init;
    logic             w_s0;
    logic             w_c0;
    logic             w_s;
    logic             w_c1;
    logic             w_carry_next;
    logic [WIDTH:0]   w_sum_cat;
    logic [WIDTH-1:0] w_sum_next;

`ifdef SERIAL_ADD_SUB_EN
    logic r_sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub <= 1'b0;
        end else if (w_accept) begin
            r_sub <= sub;
        end
    end

    // Subtract is a + ~b + 1: invert b as it is shifted, seed carry with 1.
    assign w_b_bit      = r_b_sh[0] ^ r_sub;
    assign w_carry_init = sub;
`else
    assign w_b_bit      = r_b_sh[0];
    assign w_carry_init = 1'b0;
`endif

    half_adder u_ha0 (
        .a (r_a_sh[0]),
        .b (w_b_bit),
        .s (w_s0),
        .c (w_c0)
    );

    half_adder u_ha1 (
        .a (w_s0),
        .b (r_carry),
        .s (w_s),
        .c (w_c1)
    );

    assign w_carry_next = w_c0 | w_c1;
    assign w_sum_cat    = {w_s, r_sum};
    assign w_sum_next   = w_sum_cat[WIDTH:1];
    assign w_accept     = in_valid && (r_state == ST_IDLE);
    assign w_last       = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_c_out <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= w_carry_init;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_carry <= w_carry_next;
            r_sum   <= w_sum_next;
            // The counter stops at its last value rather than wrapping.
            if (w_last) begin
                r_c_out <= w_carry_next;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign sum   = r_sum;
    assign c_out = r_c_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for serial_add_ctrl: an 8-bit instance and a 1-bit instance.
module tb_serial_add_ctrl;

    typedef struct {
        logic [7:0] s;
        logic       c;
        int         acc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, c_out, busy;
    logic [7:0] a, b, sum;
    logic       in_valid1, in_ready1, out_valid1, out_ready1, c_out1, busy1;
    logic       a1, b1, sum1;
`ifdef SERIAL_ADD_SUB_EN
    logic       sub_i;
    logic       sub1;
`endif

    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    exp_t q0[$];
    exp_t q1[$];
    bit   prev_v0 = 0, prev_r0 = 0, prev_v1 = 0, prev_r1 = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub_i),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .c_out(c_out), .busy(busy)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub1),
`endif
        .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
        .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
        .c_out(c_out1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v0 = 0;
            prev_r0 = 0;
        end else begin
            if (out_valid) begin
                if (q0.size() == 0) begin
                    check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    check("sum", {24'd0, sum}, {24'd0, q0[0].s});
                    check("c_out", {31'd0, c_out}, {31'd0, q0[0].c});
                    if (!prev_v0) check("latency", cyc - q0[0].acc, 32'd8);
                    if (out_ready) void'(q0.pop_front());
                end
            end else if (prev_v0 && !prev_r0) begin
                check("out_valid_dropped", {31'd0, out_valid}, 32'd1);
            end
            prev_v0 = out_valid;
            prev_r0 = out_ready;
        end
    end

    // Monitor for the 1-bit instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v1 = 0;
            prev_r1 = 0;
        end else begin
            if (out_valid1) begin
                if (q1.size() == 0) begin
                    check("w1_spurious_out_valid", {31'd0, out_valid1}, 32'd0);
                end else begin
                    check("w1_sum", {31'd0, sum1}, {31'd0, q1[0].s[0]});
                    check("w1_c_out", {31'd0, c_out1}, {31'd0, q1[0].c});
                    if (!prev_v1) check("w1_latency", cyc - q1[0].acc, 32'd1);
                    if (out_ready1) void'(q1.pop_front());
                end
            end else if (prev_v1 && !prev_r1) begin
                check("w1_out_valid_dropped", {31'd0, out_valid1}, 32'd1);
            end
            prev_v1 = out_valid1;
            prev_r1 = out_ready1;
        end
    end

    task automatic send0(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] es,
                         input logic ec, input bit keep, output int acc);
        int n = 0;
        exp_t e;
        a        = ta;
        b        = tb_;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", {31'd0, in_ready}, 32'd1);
        acc   = cyc + 1;
        e.s   = es;
        e.c   = ec;
        e.acc = acc;
        q0.push_back(e);
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic send1(input logic ta, input logic tb_, input logic es, input logic ec);
        int n = 0;
        exp_t e;
        a1        = ta;
        b1        = tb_;
        in_valid1 = 1'b1;
        @(negedge clk);
        while (!in_ready1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("w1_accept_wait", {31'd0, in_ready1}, 32'd1);
        e.s   = {7'd0, es};
        e.c   = ec;
        e.acc = cyc + 1;
        q1.push_back(e);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
    endtask

    task automatic drain0();
        int n = 0;
        while (q0.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", q0.size(), 32'd0);
    endtask

    task automatic drain1();
        int n = 0;
        while (q1.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("w1_drain", q1.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d fails=%0d", checks, fails);
        $fatal(1);
    end

    initial begin
        int acc_a, acc_b, n;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        a1         = 1'b0;
        b1         = 1'b0;
        out_ready1 = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        sub_i      = 1'b0;
        sub1       = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_c_out", {31'd0, c_out}, 32'd0);
        check("w1_rst_in_ready", {31'd0, in_ready1}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic add with carry ripple into bit 4.
        out_ready = 1'b1;
        send0(8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, acc_a);
        check("busy_in_run", {31'd0, busy}, 32'd1);
        check("in_ready_in_run", {31'd0, in_ready}, 32'd0);
        drain0();

        // Wrap-around with carry-out, consumer stalls for 5 cycles.
        out_ready = 1'b0;
        send0(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, acc_a);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            n++;
        end
        repeat (5) @(posedge clk);
        #1;
        check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        check("stall_sum", {24'd0, sum}, 32'd0);
        check("stall_c_out", {31'd0, c_out}, 32'd1);
        out_ready = 1'b1;
        drain0();

        // in_valid held high across two operand pairs, out_ready held high.
        send0(8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b1, acc_a);
        send0(8'h80, 8'h80, 8'h00, 1'b1, 1'b0, acc_b);
        check("accept_spacing", acc_b - acc_a, 32'd10);
        drain0();

        // Reset in the middle of RUN aborts the operation.
        send0(8'h12, 8'h34, 8'h46, 1'b0, 1'b0, acc_a);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_sum", {24'd0, sum}, 32'd0);
        check("abort_c_out", {31'd0, c_out}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        q0.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send0(8'h03, 8'h04, 8'h07, 1'b0, 1'b0, acc_a);
        drain0();

`ifdef SERIAL_ADD_SUB_EN
        sub_i = 1'b1;
        send0(8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, acc_a);
        drain0();
        send0(8'h07, 8'h05, 8'h02, 1'b1, 1'b0, acc_a);
        drain0();
        sub_i = 1'b0;
`endif

        // WIDTH=1 instance: full truth table.
        send1(1'b0, 1'b0, 1'b0, 1'b0);
        send1(1'b1, 1'b0, 1'b1, 1'b0);
        send1(1'b0, 1'b1, 1'b1, 1'b0);
        send1(1'b1, 1'b1, 1'b0, 1'b1);
        drain1();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
